// File: rtl/ber_sync_sequencer_if.sv
// Control bundle between the RX enable/strobe side and the BER counter sequencer.
// master drives the request inputs; slave is the sequencer that produces counter controls.
interface ber_sync_sequencer_if #(
  parameter int CIDX = 9
);
  logic            i_en_rx;
  logic            i_ctrl;
  logic            i_start;
  logic            i_resync;
  logic            o_en_rx;
  logic            o_synchro_en;
  logic            o_prbs_cmp_curr_addr_done;
  logic            o_ber_counter_en;
  logic [CIDX-1:0] o_cand_idx;
  logic            o_sync_done;
  logic [1:0]      o_state;

  modport master (
    output i_en_rx, i_ctrl, i_start, i_resync,
    input  o_en_rx, o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en,
           o_cand_idx, o_sync_done, o_state
  );

  modport slave (
    input  i_en_rx, i_ctrl, i_start, i_resync,
    output o_en_rx, o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en,
           o_cand_idx, o_sync_done, o_state
  );
endinterface

// File: rtl/ber_sync_sequencer.sv
// Sweeps PRBS latency candidates one window each, then enables BER counting; flushes on resync.
// Outputs decode registered state only (o_en_rx also gates i_en_rx); no backpressure, i_ctrl strobes pace the sweep.
module ber_sync_sequencer #(
  parameter int PRBS_MAX_CYCLES = 511,
  parameter int WINDOW_LEN      = 511,
  parameter int FLUSH_CYCLES    = 4
) (
  input  logic                 clk,
  input  logic                 i_reset,
  ber_sync_sequencer_if.slave  bus
);
  localparam int CIDX = $clog2(PRBS_MAX_CYCLES);
  localparam int WCW  = $clog2(WINDOW_LEN + 1);
  localparam int FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [WCW-1:0]  WIN_LAST   = WCW'(WINDOW_LEN);
  localparam logic [CIDX-1:0] CAND_LAST  = CIDX'(PRBS_MAX_CYCLES - 1);
  localparam logic [FCW-1:0]  FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    SYNC  = 2'd2,
    COUNT = 2'd3
  } state_t;

  state_t          state;
  logic [WCW-1:0]  win_cnt;
  logic [CIDX-1:0] cand;
  logic [FCW-1:0]  flush_cnt;
  logic            sync_done;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      win_cnt   <= '0;
      cand      <= '0;
      flush_cnt <= '0;
      sync_done <= 1'b0;
    end else begin
      sync_done <= 1'b0;
      if (!bus.i_en_rx) begin
        state     <= IDLE;
        win_cnt   <= '0;
        cand      <= '0;
        flush_cnt <= '0;
      end else if (bus.i_resync && (state == SYNC || state == COUNT)) begin
        state     <= FLUSH;
        win_cnt   <= '0;
        cand      <= '0;
        flush_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_start) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
          FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              state     <= SYNC;
              win_cnt   <= '0;
              cand      <= '0;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + FCW'(1);
            end
          end
          SYNC: begin
            if (bus.i_ctrl) begin
              if (win_cnt != WIN_LAST) begin
                win_cnt <= win_cnt + WCW'(1);
              end else begin
                win_cnt <= '0;
                // Last candidate stays on o_cand_idx through COUNT instead of wrapping.
                if (cand == CAND_LAST) begin
                  state     <= COUNT;
                  sync_done <= 1'b1;
                end else begin
                  cand <= cand + CIDX'(1);
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.o_en_rx                   = bus.i_en_rx & (state != FLUSH);
  assign bus.o_synchro_en              = (state == SYNC);
  assign bus.o_prbs_cmp_curr_addr_done = (state == SYNC) && (win_cnt == WIN_LAST);
  assign bus.o_ber_counter_en          = (state == COUNT);
  assign bus.o_cand_idx                = cand;
  assign bus.o_sync_done               = sync_done;
  assign bus.o_state                   = state;
endmodule

// File: tb/tb_ber_sync_sequencer.sv
// Randomized bench for ber_sync_sequencer against a strobe-counting reference model.
module tb_ber_sync_sequencer;
  localparam int P    = 7;
  localparam int W    = 5;
  localparam int F    = 4;
  localparam int CIDX = $clog2(P);
  localparam int SWEEP = P * (W + 1);

  logic clk;
  logic i_reset;

  ber_sync_sequencer_if #(.CIDX(CIDX)) bus ();

  ber_sync_sequencer #(
    .PRBS_MAX_CYCLES(P),
    .WINDOW_LEN(W),
    .FLUSH_CYCLES(F)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state number, clocks spent flushing, strobes consumed by the search.
  int m_st;
  int m_fl;
  int m_str;
  bit m_pulse;

  int tick;
  int flush_low, strobes, done_marks, sd_cnt, ber_cnt, sync_clks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_fl = 0; m_str = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic en, input logic ctrl, input logic start, input logic rs);
    m_pulse = 0;
    if (!i_reset) model_reset();
    else if (!en) begin
      m_st = 0; m_fl = 0; m_str = 0;
    end else if (rs && m_st >= 2) begin
      m_st = 1; m_fl = 0; m_str = 0;
    end else begin
      case (m_st)
        0: if (start) begin m_st = 1; m_fl = 0; end
        1: begin
          m_fl++;
          if (m_fl == F) begin m_st = 2; m_str = 0; end
        end
        2: if (ctrl) begin
          if (m_str == SWEEP - 1) begin m_st = 3; m_pulse = 1; end
          else m_str++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic clear_tallies();
    flush_low = 0; strobes = 0; done_marks = 0; sd_cnt = 0; ber_cnt = 0; sync_clks = 0;
  endtask

  // Called at a negedge: apply inputs, check outputs, advance model across the next posedge.
  task automatic step(input logic en, input logic ctrl, input logic start, input logic rs);
    bus.i_en_rx = en; bus.i_ctrl = ctrl; bus.i_start = start; bus.i_resync = rs;
    #1;
    chk("state", bus.o_state, m_st);
    chk("en_rx", bus.o_en_rx, en & (m_st != 1));
    chk("synchro_en", bus.o_synchro_en, m_st == 2);
    chk("addr_done", bus.o_prbs_cmp_curr_addr_done, (m_st == 2) && ((m_str % (W + 1)) == W));
    chk("ber_en", bus.o_ber_counter_en, m_st == 3);
    chk("cand_idx", bus.o_cand_idx, (m_st == 2) ? (m_str / (W + 1)) : ((m_st == 3) ? (P - 1) : 0));
    chk("sync_done", bus.o_sync_done, m_pulse);
    if (en && !bus.o_en_rx) flush_low++;
    if (ctrl && bus.o_synchro_en) strobes++;
    if (ctrl && bus.o_prbs_cmp_curr_addr_done) done_marks++;
    if (bus.o_sync_done) sd_cnt++;
    if (bus.o_ber_counter_en) ber_cnt++;
    if (bus.o_synchro_en) sync_clks++;
    model_step(en, ctrl, start, rs);
    tick++;
    @(negedge clk);
  endtask

  function automatic logic strobe4();
    return (tick % 4) == 3;
  endfunction

  initial begin
    bit hit;
    int after;
    logic c, r;
    tick = 0;
    i_reset = 1'b0;
    bus.i_en_rx = 0; bus.i_ctrl = 0; bus.i_start = 0; bus.i_resync = 0;
    model_reset();
    clear_tallies();
    @(negedge clk);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    i_reset = 1'b1;

    // Full sweep with a strobe every 4th clk.
    clear_tallies();
    step(1, 0, 1, 0);
    for (int n = 0; n < 400 && m_st != 3; n++) step(1, strobe4(), 0, 0);
    chk("t2_reach_count", bus.o_ber_counter_en, 1);
    repeat (8) step(1, strobe4(), 0, 0);
    chk("t2_flush_clks", flush_low, F);
    chk("t2_strobes", strobes, SWEEP);
    chk("t2_done_marks", done_marks, P);
    chk("t2_sync_done_pulses", sd_cnt, 1);

    // Resync out of COUNT, restart search.
    clear_tallies();
    step(1, 0, 0, 1);
    for (int n = 0; n < 200 && !(m_st == 2 && m_str >= W + 1); n++) step(1, strobe4(), 0, 0);
    chk("t3_flush_clks", flush_low, F);
    chk("t3_in_sync", bus.o_synchro_en, 1);

    // RX drop at candidate 3; IDLE must hold without i_start.
    for (int n = 0; n < 200 && !(m_st == 2 && m_str / (W + 1) == 3); n++) step(1, strobe4(), 0, 0);
    chk("t4_cand3", bus.o_cand_idx, 3);
    step(0, strobe4(), 0, 0);
    repeat (10) step(1, 1'($urandom % 2), 0, 1'($urandom % 2));
    chk("t4_idle", bus.o_state, 0);
    chk("t4_ctrl_outs", {bus.o_synchro_en, bus.o_prbs_cmp_curr_addr_done,
                         bus.o_ber_counter_en, bus.o_sync_done}, 0);

    // i_ctrl tied high, stray i_start pulses.
    clear_tallies();
    step(1, 0, 1, 0);
    for (int n = 0; n < 100 && m_st != 3; n++) step(1, 1, 1'($urandom % 2), 0);
    chk("t5_sync_clks", sync_clks, SWEEP);
    step(1, 1, 1, 0);
    chk("t5_sync_done_pulses", sd_cnt, 1);

    // Resync coincident with the final done strobe.
    step(1, 0, 0, 1);
    clear_tallies();
    hit = 0; after = 0;
    for (int n = 0; n < 400 && after < 30; n++) begin
      c = strobe4();
      r = c && m_st == 2 && m_str == SWEEP - 1;
      if (r) hit = 1;
      if (hit) after++;
      step(1, c, 0, r);
    end
    chk("t6_hit", hit, 1);
    chk("t6_sync_done", sd_cnt, 0);
    chk("t6_ber_en", ber_cnt, 0);

    // Async reset between edges while done is asserted.
    for (int n = 0; n < 100 && !(m_st == 2 && (m_str % (W + 1)) == W && m_str > W); n++)
      step(1, strobe4(), 0, 0);
    chk("t1_pre_done", bus.o_prbs_cmp_curr_addr_done, 1);
    #2 i_reset = 1'b0;
    #1;
    chk("t1_synchro", bus.o_synchro_en, 0);
    chk("t1_done", bus.o_prbs_cmp_curr_addr_done, 0);
    chk("t1_cand", bus.o_cand_idx, 0);
    chk("t1_state", bus.o_state, 0);
    chk("t1_en_rx", bus.o_en_rx, 1);
    model_reset();
    @(negedge clk);
    step(1, 0, 0, 0);
    i_reset = 1'b1;

    // Randomized traffic, alternating sparse strobes and tied-high strobes.
    for (int n = 0; n < 4000; n++) begin
      logic en, st, rs, ct;
      en = ($urandom % 150) != 0;
      rs = ($urandom % 120) == 0;
      st = ($urandom % 6) == 0;
      ct = ((n / 200) % 2 == 1) ? 1'b1 : (($urandom % 3) == 0);
      step(en, ct, st, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
